// File: rtl/core_pkg.sv
// Shared pipeline types for the RV32I core: the EX/MEM and MEM/WB bundles,
// the load/store unit state encoding and the access-legality helper.
package core_pkg;

    localparam int DATA_WIDTH          = 32;
    localparam int BYTE_WIDTH          = 8;
    localparam int BE_WIDTH            = DATA_WIDTH / BYTE_WIDTH;
    localparam int DATA_MEM_ADDR_WIDTH = 10;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rd_addr;
        logic        RegWrite;
        logic [1:0]  WBSel;
        logic        MemRead;
        logic        MemWrite;
    } ex_mem_data_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] alu_result;
        logic [31:0] mem_rdata;
        logic [31:0] pc_plus4;
        logic [4:0]  rd_addr;
        logic        RegWrite;
        logic [1:0]  WBSel;
    } mem_wb_data_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_e;

    // True when a memory access must be suppressed: misaligned, unknown width, or both directions set.
    function automatic logic access_fault(input logic is_rd, input logic is_wr,
                                          input logic [2:0] f3, input logic [1:0] off);
        logic fault;
        fault = 1'b0;
        if (is_rd && is_wr) begin
            fault = 1'b1;
        end else if (is_rd) begin
            case (f3)
                F3_B, F3_BU: fault = 1'b0;
                F3_H, F3_HU: fault = off[0];
                F3_W:        fault = (off != 2'b00);
                default:     fault = 1'b1;
            endcase
        end else if (is_wr) begin
            case (f3)
                F3_B:    fault = 1'b0;
                F3_H:    fault = off[0];
                F3_W:    fault = (off != 2'b00);
                default: fault = 1'b1;
            endcase
        end
        return fault;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/halfword/word from a raw memory word and
// sign- or zero-extends it according to the load funct3.
module mem_load_align
    import core_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_byte_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_byte_off, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (i_funct3)
            F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   o_data = {24'd0, w_shifted[7:0]};
            F3_HU:   o_data = {16'd0, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on a req/gnt/rvalid data port, stalls
// upstream while a transaction is open, and registers the MEM/WB bundle.
module mem_access_stage
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = DATA_MEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  ex_mem_data_t          ex_mem_i,
    input  logic                  ex_mem_valid_i,
    output logic                  mem_stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [31:0]           dmem_wdata_o,
    output logic [BE_WIDTH-1:0]   dmem_be_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [31:0]           dmem_rdata_i,
    output mem_wb_data_t          mem_wb_o,
    output logic                  mem_wb_valid_o,
    output logic                  misalign_o
);

    lsu_state_e            r_state;
    logic                  r_req;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [BE_WIDTH-1:0]   r_be;
    logic [2:0]            r_f3;
    logic [1:0]            r_off;
    mem_wb_data_t          r_pend;
    mem_wb_data_t          r_wb;
    logic                  r_wb_valid;
    logic                  r_misalign;

    logic [2:0]            w_f3;
    logic [1:0]            w_off;
    logic                  w_mem_op;
    logic                  w_fault;
    logic [31:0]           w_st_wdata;
    logic [BE_WIDTH-1:0]   w_st_be;
    logic [31:0]           w_load_data;
    mem_wb_data_t          w_pass;
    mem_wb_data_t          w_direct;
    mem_wb_data_t          w_wb_load;
    logic                  w_unused;

    assign w_f3     = ex_mem_i.instruction[14:12];
    assign w_off    = ex_mem_i.alu_result[1:0];
    assign w_mem_op = ex_mem_valid_i && (ex_mem_i.MemRead || ex_mem_i.MemWrite);
    assign w_fault  = access_fault(ex_mem_i.MemRead, ex_mem_i.MemWrite, w_f3, w_off);
    // Address bits above the data-memory window wrap and are deliberately dropped.
    assign w_unused = ^ex_mem_i.alu_result[31:ADDR_WIDTH+2];

    mem_load_align u_load_align (
        .i_rdata    (dmem_rdata_i),
        .i_byte_off (r_off),
        .i_funct3   (r_f3),
        .o_data     (w_load_data)
    );

    always_comb begin
        w_st_wdata = ex_mem_i.rs2_data;
        w_st_be    = 4'b1111;
        case (w_f3[1:0])
            2'b00: begin
                w_st_wdata = {4{ex_mem_i.rs2_data[7:0]}};
                w_st_be    = 4'b0001 << w_off;
            end
            2'b01: begin
                w_st_wdata = {2{ex_mem_i.rs2_data[15:0]}};
                w_st_be    = w_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_st_wdata = ex_mem_i.rs2_data;
                w_st_be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_pass             = '0;
        w_pass.instruction = ex_mem_i.instruction;
        w_pass.alu_result  = ex_mem_i.alu_result;
        w_pass.pc_plus4    = ex_mem_i.pc_plus4;
        w_pass.rd_addr     = ex_mem_i.rd_addr;
        w_pass.RegWrite    = ex_mem_i.RegWrite;
        w_pass.WBSel       = ex_mem_i.WBSel;
        // A suppressed memory access must not write the register file.
        w_direct           = w_pass;
        w_direct.RegWrite  = ex_mem_i.RegWrite & ~w_mem_op;
        w_wb_load           = r_pend;
        w_wb_load.mem_rdata = w_load_data;
    end

    always_comb begin
        mem_stall_o = 1'b0;
        case (r_state)
            LSU_IDLE: mem_stall_o = w_mem_op && !w_fault;
            LSU_REQ:  mem_stall_o = !(dmem_gnt_i && r_we);
            LSU_WAIT: mem_stall_o = !dmem_rvalid_i;
            default:  mem_stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LSU_IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_f3       <= '0;
            r_off      <= '0;
            r_pend     <= '0;
            r_wb       <= '0;
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                LSU_IDLE: begin
                    if (w_mem_op && !w_fault) begin
                        r_req   <= 1'b1;
                        r_we    <= ex_mem_i.MemWrite;
                        r_addr  <= ex_mem_i.alu_result[ADDR_WIDTH+1:2];
                        r_wdata <= w_st_wdata;
                        r_be    <= ex_mem_i.MemWrite ? w_st_be : '0;
                        r_f3    <= w_f3;
                        r_off   <= w_off;
                        r_pend  <= w_pass;
                        r_state <= LSU_REQ;
                    end else if (ex_mem_valid_i) begin
                        r_wb       <= w_direct;
                        r_wb_valid <= 1'b1;
                        r_misalign <= w_mem_op;
                    end
                end
                LSU_REQ: begin
                    if (dmem_gnt_i) begin
                        r_req <= 1'b0;
                        if (r_we) begin
                            r_wb       <= r_pend;
                            r_wb_valid <= 1'b1;
                            r_state    <= LSU_IDLE;
                        end else begin
                            r_state <= LSU_WAIT;
                        end
                    end
                end
                LSU_WAIT: begin
                    if (dmem_rvalid_i) begin
                        r_wb       <= w_wb_load;
                        r_wb_valid <= 1'b1;
                        r_state    <= LSU_IDLE;
                    end
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

    assign dmem_req_o     = r_req;
    assign dmem_we_o      = r_we;
    assign dmem_addr_o    = r_addr;
    assign dmem_wdata_o   = r_wdata;
    assign dmem_be_o      = r_be;
    assign mem_wb_o       = r_wb;
    assign mem_wb_valid_o = r_wb_valid;
    assign misalign_o     = r_misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed loads/stores against a
// configurable-latency memory responder, with a decoupled MEM/WB monitor.
module tb_mem_access_stage;
    import core_pkg::*;

    typedef struct packed {
        mem_wb_data_t wb;
        logic         mis;
    } expItem_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    ex_mem_data_t exMem = '0;
    logic         exValid = 1'b0;
    logic         memStall;
    logic         dmemReq, dmemWe;
    logic [9:0]   dmemAddr;
    logic [31:0]  dmemWdata;
    logic [3:0]   dmemBe;
    logic         dmemGnt, dmemRvalid;
    logic [31:0]  dmemRdata;
    mem_wb_data_t memWb;
    logic         memWbValid, misalign;

    int checks = 0;
    int failures = 0;
    expItem_t expQ[$];

    int          gntDelay = 0;
    int          waitCycles = 0;
    logic [31:0] respRdata = '0;
    logic        forceRvalid = 1'b0;
    int          reqIssues = 0;
    logic [9:0]  snapAddr;
    logic [31:0] snapWdata;
    logic [3:0]  snapBe;
    logic        snapWe;

    mem_access_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_mem_i       (exMem),
        .ex_mem_valid_i (exValid),
        .mem_stall_o    (memStall),
        .dmem_req_o     (dmemReq),
        .dmem_we_o      (dmemWe),
        .dmem_addr_o    (dmemAddr),
        .dmem_wdata_o   (dmemWdata),
        .dmem_be_o      (dmemBe),
        .dmem_gnt_i     (dmemGnt),
        .dmem_rvalid_i  (dmemRvalid),
        .dmem_rdata_i   (dmemRdata),
        .mem_wb_o       (memWb),
        .mem_wb_valid_o (memWbValid),
        .misalign_o     (misalign)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic checkWb(input string name, input mem_wb_data_t actual, input mem_wb_data_t expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic ex_mem_data_t mkEx(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rs2,
                                          input logic [4:0] rd, input logic rdEn, input logic wrEn,
                                          input logic regWr, input logic [31:0] pc);
        ex_mem_data_t e;
        e             = '0;
        e.instruction = {17'd0, f3, rd, wrEn ? 7'h23 : (rdEn ? 7'h03 : 7'h33)};
        e.alu_result  = alu;
        e.rs2_data    = rs2;
        e.pc_plus4    = pc;
        e.rd_addr     = rd;
        e.RegWrite    = regWr;
        e.WBSel       = rdEn ? 2'd1 : 2'd0;
        e.MemRead     = rdEn;
        e.MemWrite    = wrEn;
        return e;
    endfunction

    function automatic mem_wb_data_t mkWb(input ex_mem_data_t e, input logic [31:0] rdata, input logic fault);
        mem_wb_data_t w;
        w.instruction = e.instruction;
        w.alu_result  = e.alu_result;
        w.mem_rdata   = rdata;
        w.pc_plus4    = e.pc_plus4;
        w.rd_addr     = e.rd_addr;
        w.RegWrite    = e.RegWrite & ~fault;
        w.WBSel       = e.WBSel;
        return w;
    endfunction

    // Called at a negedge; returns at the negedge after the instruction is accepted.
    task automatic applyStimulus(input ex_mem_data_t e, input logic [31:0] expRdata, input logic expFault,
                                 input bit corrupt, output int stallCycles);
        int  n;
        bit  done;
        expQ.push_back({mkWb(e, expRdata, expFault), expFault});
        exMem       = e;
        exValid     = 1'b1;
        stallCycles = 0;
        n           = 0;
        done        = 0;
        while (!done) begin
            #1;
            if (!memStall) done = 1;
            else stallCycles++;
            if (corrupt && !done && stallCycles == 2) begin
                exMem.alu_result = exMem.alu_result ^ 32'h0000_0FF0;
                exMem.rd_addr    = 5'd31;
                exMem.pc_plus4   = 32'hBAD0_0000;
            end
            @(negedge clk);
            n++;
            if (!done && n >= 50) begin
                checks++;
                failures++;
                $display("[TB] FAIL acceptTimeout actual=%0d cycles required<50", n);
                done = 1;
            end
        end
        exValid = 1'b0;
    endtask

    // Memory responder: grants after gntDelay request cycles, returns load data waitCycles after the grant.
    initial begin
        int reqCnt = 0;
        int waitCnt = 0;
        bit inReq = 0;
        bit loadPending = 0;
        dmemGnt = 1'b0;
        dmemRvalid = 1'b0;
        dmemRdata = '0;
        forever begin
            @(negedge clk);
            dmemGnt    = 1'b0;
            dmemRvalid = forceRvalid;
            dmemRdata  = respRdata;
            if (!rst_n) begin
                reqCnt = 0; waitCnt = 0; inReq = 0; loadPending = 0;
            end else if (dmemReq) begin
                if (!inReq) begin
                    inReq = 1;
                    reqIssues++;
                    snapAddr = dmemAddr; snapWdata = dmemWdata; snapBe = dmemBe; snapWe = dmemWe;
                end else begin
                    checkOutput("reqAddrStable", 32'(dmemAddr), 32'(snapAddr));
                    checkOutput("reqBeStable", 32'(dmemBe), 32'(snapBe));
                end
                if (reqCnt == gntDelay) begin
                    dmemGnt = 1'b1;
                    reqCnt  = 0;
                    inReq   = 0;
                    if (!dmemWe) begin
                        loadPending = 1;
                        waitCnt     = 0;
                    end
                end else begin
                    reqCnt++;
                end
            end else if (loadPending) begin
                if (waitCnt == waitCycles) begin
                    dmemRvalid  = 1'b1;
                    loadPending = 0;
                end else begin
                    waitCnt++;
                end
            end
        end
    end

    // Monitor: every presented MEM/WB bundle is matched against the oldest expectation.
    always @(negedge clk) begin
        expItem_t e;
        if (rst_n && memWbValid) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedWb actual=%h required=none", memWb);
            end else begin
                e = expQ.pop_front();
                checkWb("memWb", memWb, e.wb);
                checkOutput("misalignWithWb", 32'(misalign), 32'(e.mis));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout actual=expired required=finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int stall;
        int reqBefore;
        ex_mem_data_t e;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("resetReq", 32'(dmemReq), 0);
        checkOutput("resetWe", 32'(dmemWe), 0);
        checkOutput("resetWbValid", 32'(memWbValid), 0);
        checkOutput("resetMisalign", 32'(misalign), 0);
        checkOutput("resetAddr", 32'(dmemAddr), 0);
        checkOutput("resetWdata", dmemWdata, 0);
        checkOutput("resetBe", 32'(dmemBe), 0);
        checkWb("resetMemWb", memWb, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        e = mkEx(F3_W, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 32'h104);
        applyStimulus(e, 32'h0, 1'b0, 0, stall);
        checkOutput("swStall", stall, 1);
        checkOutput("swWbAt2Edges", 32'(memWbValid), 1);
        checkOutput("swAddr", 32'(snapAddr), 32'h4);
        checkOutput("swBe", 32'(snapBe), 32'hF);
        checkOutput("swWdata", snapWdata, 32'hDEADBEEF);
        checkOutput("swWe", 32'(snapWe), 1);

        respRdata = 32'hDEADBEEF;
        e = mkEx(F3_W, 32'h10, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 32'h108);
        applyStimulus(e, 32'hDEADBEEF, 1'b0, 0, stall);
        checkOutput("lwStall", stall, 2);
        checkOutput("lwWbAt3Edges", 32'(memWbValid), 1);
        checkOutput("lwBe", 32'(snapBe), 0);
        checkOutput("lwWe", 32'(snapWe), 0);

        e = mkEx(F3_B, 32'h13, 32'h000000A5, 5'd0, 1'b0, 1'b1, 1'b0, 32'h10C);
        applyStimulus(e, 32'h0, 1'b0, 0, stall);
        checkOutput("sbBe", 32'(snapBe), 32'h8);
        checkOutput("sbWdata", snapWdata, 32'hA5A5A5A5);
        checkOutput("sbAddr", 32'(snapAddr), 32'h4);

        e = mkEx(F3_H, 32'h12, 32'h00001234, 5'd0, 1'b0, 1'b1, 1'b0, 32'h110);
        applyStimulus(e, 32'h0, 1'b0, 0, stall);
        checkOutput("shBe", 32'(snapBe), 32'hC);
        checkOutput("shWdata", snapWdata, 32'h12341234);

        respRdata = 32'h0080FF00;
        applyStimulus(mkEx(F3_B,  32'h12, 0, 5'd1, 1'b1, 1'b0, 1'b1, 32'h114), 32'hFFFFFF80, 1'b0, 0, stall);
        applyStimulus(mkEx(F3_BU, 32'h12, 0, 5'd2, 1'b1, 1'b0, 1'b1, 32'h118), 32'h00000080, 1'b0, 0, stall);
        applyStimulus(mkEx(F3_HU, 32'h12, 0, 5'd3, 1'b1, 1'b0, 1'b1, 32'h11C), 32'h00000080, 1'b0, 0, stall);
        applyStimulus(mkEx(F3_H,  32'h10, 0, 5'd4, 1'b1, 1'b0, 1'b1, 32'h120), 32'hFFFFFF00, 1'b0, 0, stall);
        applyStimulus(mkEx(F3_B,  32'h11, 0, 5'd5, 1'b1, 1'b0, 1'b1, 32'h124), 32'hFFFFFFFF, 1'b0, 0, stall);

        gntDelay   = 3;
        waitCycles = 1;
        respRdata  = 32'h13579BDF;
        applyStimulus(mkEx(F3_W, 32'h20, 0, 5'd6, 1'b1, 1'b0, 1'b1, 32'h128), 32'h13579BDF, 1'b0, 1, stall);
        checkOutput("bpStall", stall, 6);
        checkOutput("bpAddr", 32'(snapAddr), 32'h8);
        gntDelay   = 0;
        waitCycles = 0;

        reqBefore = reqIssues;
        applyStimulus(mkEx(F3_W, 32'h102, 0, 5'd8, 1'b1, 1'b0, 1'b1, 32'h12C), 32'h0, 1'b1, 0, stall);
        checkOutput("misStall", stall, 0);
        @(negedge clk);
        checkOutput("misPulseOneCycle", 32'(misalign), 0);
        applyStimulus(mkEx(3'd3, 32'h0, 0, 5'd9, 1'b1, 1'b0, 1'b1, 32'h130), 32'h0, 1'b1, 0, stall);
        applyStimulus(mkEx(3'd4, 32'h4, 0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h134), 32'h0, 1'b1, 0, stall);
        applyStimulus(mkEx(F3_W, 32'h8, 0, 5'd10, 1'b1, 1'b1, 1'b1, 32'h138), 32'h0, 1'b1, 0, stall);
        checkOutput("faultNoReq", reqIssues, reqBefore);

        applyStimulus(mkEx(3'd0, 32'hCAFEF00D, 32'h1, 5'd11, 1'b0, 1'b0, 1'b1, 32'h13C), 32'h0, 1'b0, 0, stall);
        checkOutput("addStall", stall, 0);
        @(negedge clk);
        checkOutput("invalidNoWb", 32'(memWbValid), 0);

        waitCycles = 1000;
        exMem   = mkEx(F3_W, 32'h30, 0, 5'd12, 1'b1, 1'b0, 1'b1, 32'h140);
        exValid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exValid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetReq", 32'(dmemReq), 0);
        checkOutput("midResetStall", 32'(memStall), 0);
        checkWb("midResetMemWb", memWb, '0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        waitCycles = 0;
        @(posedge clk);
        #1;
        forceRvalid = 1'b1;
        @(posedge clk);
        #1;
        forceRvalid = 1'b0;
        checkOutput("rvalidAfterResetWb", 32'(memWbValid), 0);
        checkOutput("rvalidAfterResetReq", 32'(dmemReq), 0);
        checkOutput("rvalidAfterResetStall", 32'(memStall), 0);
        @(negedge clk);
        applyStimulus(mkEx(3'd0, 32'h00000042, 32'h2, 5'd13, 1'b0, 1'b0, 1'b1, 32'h144), 32'h0, 1'b0, 0, stall);
        checkOutput("addAfterResetStall", stall, 0);
        checkOutput("addAfterResetWb", 32'(memWbValid), 1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardDrained", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
